// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] NOP_IR           = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_ifid.sv
// IF/ID pipeline slot: load captures pc/ir and sets valid, flush clears valid only.
module ifid_reg
  import fetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_ir,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_ir
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ir;

  // Flush wins over load; payload is left untouched on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_ir    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_ir    <= i_ir;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_ir    = r_ir;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, redirect handling and the IF/ID slot.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects raise misalign_exc and halt fetch.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_pc,
  input  logic [XLEN-1:0] imem_ir,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_ir
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_exc
`endif
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            w_load;
  logic            w_flush;
  logic            w_slot_free;
  logic            w_id_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            r_misalign;
  logic            w_misalign_set;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  assign w_slot_free = !w_id_valid || id_ready;

  // Redirect outranks decode back-pressure; HALT absorbs everything until reset.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_flush      = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_misalign_set = 1'b0;
`endif
    case (r_state)
      RUN: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (redirect_pc[1:0] != 2'b00) begin
            w_state_next   = HALT;
            w_misalign_set = 1'b1;
          end else begin
            w_pc_next = redirect_pc;
          end
`else
          w_pc_next = redirect_pc & PC_ALIGN_MASK;
`endif
        end else if (w_slot_free) begin
          w_load    = 1'b1;
          w_pc_next = r_pc + PC_STEP;
        end
      end
      HALT: begin
        w_flush = 1'b1;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_misalign_set) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign_exc = r_misalign;
`endif

  ifid_reg u_ifid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_pc    (r_pc),
    .i_ir    (imem_ir),
    .o_valid (w_id_valid),
    .o_pc    (id_pc),
    .o_ir    (id_ir)
  );

  assign imem_pc  = r_pc;
  assign id_valid = w_id_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; instruction memory returns the bitwise inverse of the address.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] imem_pc;
  logic [31:0] imem_ir;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_ir;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_ir        (imem_ir),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_ir          (id_ir)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_exc   (misalign_exc)
`endif
  );

  assign imem_ir = ~imem_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #22;
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid got=%h exp=%h", id_valid, 1'b0); end
    n_checks++; if (id_pc !== 32'h0) begin n_errors++; $display("FAIL rst_id_pc got=%h exp=%h", id_pc, 32'h0); end
    n_checks++; if (id_ir !== 32'h0) begin n_errors++; $display("FAIL rst_id_ir got=%h exp=%h", id_ir, 32'h0); end
    n_checks++; if (imem_pc !== 32'h0) begin n_errors++; $display("FAIL rst_imem_pc got=%h exp=%h", imem_pc, 32'h0); end
`ifdef FETCH_MISALIGN_TRAP_EN
    n_checks++; if (misalign_exc !== 1'b0) begin n_errors++; $display("FAIL rst_misalign got=%h exp=%h", misalign_exc, 1'b0); end
`endif
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(i * 4);
      step();
      n_checks++; if (id_pc !== exp_pc) begin n_errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, id_pc, exp_pc); end
      n_checks++; if (id_valid !== 1'b1) begin n_errors++; $display("FAIL seq_valid%0d got=%h exp=%h", i, id_valid, 1'b1); end
      n_checks++; if (id_ir !== ~exp_pc) begin n_errors++; $display("FAIL seq_ir%0d got=%h exp=%h", i, id_ir, ~exp_pc); end
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (id_pc !== 32'h8) begin n_errors++; $display("FAIL stall_pc%0d got=%h exp=%h", i, id_pc, 32'h8); end
      n_checks++; if (id_ir !== ~32'h8) begin n_errors++; $display("FAIL stall_ir%0d got=%h exp=%h", i, id_ir, ~32'h8); end
      n_checks++; if (imem_pc !== 32'hC) begin n_errors++; $display("FAIL stall_imem%0d got=%h exp=%h", i, imem_pc, 32'hC); end
      n_checks++; if (id_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid%0d got=%h exp=%h", i, id_valid, 1'b1); end
    end
    id_ready = 1'b1;
    step();
    n_checks++; if (id_pc !== 32'hC) begin n_errors++; $display("FAIL stall_release_pc got=%h exp=%h", id_pc, 32'hC); end
    n_checks++; if (imem_pc !== 32'h10) begin n_errors++; $display("FAIL stall_release_imem got=%h exp=%h", imem_pc, 32'h10); end
  endtask

  task automatic test_redirect();
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL redir_bubble got=%h exp=%h", id_valid, 1'b0); end
    n_checks++; if (id_pc !== 32'hC) begin n_errors++; $display("FAIL redir_hold_pc got=%h exp=%h", id_pc, 32'hC); end
    n_checks++; if (imem_pc !== 32'h100) begin n_errors++; $display("FAIL redir_imem got=%h exp=%h", imem_pc, 32'h100); end
    redirect_valid = 1'b0; id_ready = 1'b1;
    step();
    n_checks++; if (id_pc !== 32'h100) begin n_errors++; $display("FAIL redir_target_pc got=%h exp=%h", id_pc, 32'h100); end
    n_checks++; if (id_valid !== 1'b1) begin n_errors++; $display("FAIL redir_target_valid got=%h exp=%h", id_valid, 1'b1); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    n_checks++; if (id_pc !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_top got=%h exp=%h", id_pc, 32'hFFFF_FFFC); end
    step();
    n_checks++; if (id_pc !== 32'h0) begin n_errors++; $display("FAIL wrap_zero got=%h exp=%h", id_pc, 32'h0); end
    n_checks++; if (imem_pc !== 32'h4) begin n_errors++; $display("FAIL wrap_imem got=%h exp=%h", imem_pc, 32'h4); end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    n_checks++; if (misalign_exc !== 1'b1) begin n_errors++; $display("FAIL mis_flag got=%h exp=%h", misalign_exc, 1'b1); end
    n_checks++; if (imem_pc !== 32'h4) begin n_errors++; $display("FAIL mis_pc_hold got=%h exp=%h", imem_pc, 32'h4); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL mis_halt_valid%0d got=%h exp=%h", i, id_valid, 1'b0); end
      n_checks++; if (imem_pc !== 32'h4) begin n_errors++; $display("FAIL mis_halt_pc%0d got=%h exp=%h", i, imem_pc, 32'h4); end
      n_checks++; if (id_pc !== 32'h0) begin n_errors++; $display("FAIL mis_halt_idpc%0d got=%h exp=%h", i, id_pc, 32'h0); end
    end
`else
    n_checks++; if (imem_pc !== 32'h100) begin n_errors++; $display("FAIL mis_forced_align got=%h exp=%h", imem_pc, 32'h100); end
    step();
    n_checks++; if (id_pc !== 32'h100) begin n_errors++; $display("FAIL mis_target_pc got=%h exp=%h", id_pc, 32'h100); end
    n_checks++; if (id_valid !== 1'b1) begin n_errors++; $display("FAIL mis_target_valid got=%h exp=%h", id_valid, 1'b1); end
`endif
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    step();
    n_checks++; if (id_pc !== 32'h40) begin n_errors++; $display("FAIL ar_pre_pc got=%h exp=%h", id_pc, 32'h40); end
    n_checks++; if (id_valid !== 1'b1) begin n_errors++; $display("FAIL ar_pre_valid got=%h exp=%h", id_valid, 1'b1); end
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    rst = 1'b1;
    #1;
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL ar_valid got=%h exp=%h", id_valid, 1'b0); end
    n_checks++; if (imem_pc !== 32'h0) begin n_errors++; $display("FAIL ar_imem got=%h exp=%h", imem_pc, 32'h0); end
    n_checks++; if (id_pc !== 32'h0) begin n_errors++; $display("FAIL ar_id_pc got=%h exp=%h", id_pc, 32'h0); end
    redirect_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    n_checks++; if (id_pc !== 32'h0) begin n_errors++; $display("FAIL ar_restart_pc got=%h exp=%h", id_pc, 32'h0); end
    n_checks++; if (id_valid !== 1'b1) begin n_errors++; $display("FAIL ar_restart_valid got=%h exp=%h", id_valid, 1'b1); end
    step();
    n_checks++; if (id_pc !== 32'h4) begin n_errors++; $display("FAIL ar_second_pc got=%h exp=%h", id_pc, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_misalign();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first PC fetched after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port imem_pc, output, 32, byte address driven to the instruction memory.
REQ-005 SHALL have port imem_ir, input, 32, instruction word returned combinationally for imem_pc in the same cycle.
REQ-006 SHALL have port redirect_valid, input, 1, taken branch/jump from execute.
REQ-007 SHALL have port redirect_pc, input, 32, redirect target byte address.
REQ-008 SHALL have port id_ready, input, 1, decode accepts the IF/ID slot this cycle.
REQ-009 SHALL have port id_valid, output, 1, IF/ID slot holds a valid instruction.
REQ-010 SHALL have ports id_pc and id_ir, output, 32 each, PC and instruction in the IF/ID slot.
REQ-011 SHALL have port misalign_exc, output, 1, sticky misaligned-redirect flag; it SHALL be present only when FETCH_MISALIGN_TRAP_EN is defined.

Function
REQ-012 SHALL hold a 32-bit PC register; imem_pc SHALL equal it combinationally.
REQ-013 SHALL have two states: RUN and HALT; HALT is reachable only with FETCH_MISALIGN_TRAP_EN defined.
REQ-014 In RUN, the slot is free when id_valid==0 or id_ready==1.
REQ-015 In RUN with the slot free and no redirect, on the clock edge: id_pc<=PC, id_ir<=imem_ir, id_valid<=1, PC<=PC+4.
REQ-016 In RUN with the slot not free and no redirect, PC, id_pc, id_ir and id_valid SHALL hold.
REQ-017 redirect_valid SHALL take priority over id_ready in all cases: PC<=redirect_pc, id_valid<=0 (flush), id_pc/id_ir hold.
REQ-018 A redirect's target SHALL appear on id_* one edge after the redirect edge, with 1-cycle fetch latency and 1 bubble per redirect.
REQ-019 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 Without the macro, redirect_pc[1:0] SHALL be ignored and forced to 2'b00 in PC.
REQ-021 In HALT, PC, id_pc and id_ir SHALL be frozen, id_valid SHALL be 0, and redirects SHALL be ignored until reset.

Reset
REQ-022 On rst: PC=RESET_PC, id_valid=0, id_pc=0, id_ir=0, state=RUN, misalign_exc=0.
REQ-023 Reset asserted mid-operation SHALL discard the slot and any pending redirect immediately (asynchronously).
REQ-024 On the first edge after rst deasserts, id_pc SHALL become RESET_PC with id_valid=1.

Configuration
REQ-025 With macro FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0]!=0 SHALL set misalign_exc=1 and enter HALT, leave PC unchanged, and clear id_valid.
REQ-026 With FETCH_MISALIGN_TRAP_EN undefined: misalign_exc SHALL be absent, HALT SHALL not exist, and REQ-020 SHALL apply.

Structure
REQ-027 A shared package SHALL hold the state enum (RUN, HALT), the constants XLEN=32, PC_STEP=4 and NOP_IR=32'h0000_0013, and the RESET_PC default.
REQ-028 The IF/ID slot SHALL be a sub-module ifid_reg: load/flush/hold, with pc and ir fields and a valid bit.

Verification
REQ-029 Release reset with id_ready=1 and RESET_PC=0 -> id_pc sequence 0,4,8,C on consecutive edges; id_valid=1 from the first edge.
REQ-030 Hold id_ready=0 for 3 cycles while id_pc=8 -> id_pc=8, id_ir and imem_pc=C stable; on id_ready=1, next id_pc=C.
REQ-031 Assert redirect_valid with redirect_pc=0x100 while id_ready=0 -> next edge id_valid=0; following edge id_pc=0x100, id_valid=1.
REQ-032 Set PC=0xFFFF_FFFC via redirect, then run -> id_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-033 With the macro, redirect_pc=0x102 -> misalign_exc=1, id_valid=0 permanently, and a later redirect to 0x200 is ignored; without the macro -> id_pc=0x100.
REQ-034 Assert rst mid-stream at id_pc=0x40 -> id_valid=0 immediately; after release, id_pc=RESET_PC.
